// File: rtl/serial_cmd_packetizer.sv
// ---------------------------------------------------------------------------
// serial_cmd_packetizer
//
// Host-side initiator for the diff_freq_serial_out command protocol. One
// request is captured per valid/ready handshake and serialized into the UART
// byte stream. Each byte is handed to the UART TX with a one-clock start pulse,
// and the next byte follows the TX done tick.
//
//   data update (6 B): CMD_DATA, pattern[31:24..7:0], {channel, 0, mode, 2'b01}
//   freq update (7 B): CMD_FREQ, pattern[31:24..7:0], slow_period, fast_period
//
// If the TX does not report completion within TIMEOUT_CYC clocks of the start
// pulse, the packet is dropped and err_tick_o pulses. A done tick arriving on
// the timeout clock still counts as success.
//
// Optional feature: define INTER_BYTE_GAP_EN to insert GAP_CYC idle clocks
// between bytes (never after the final byte). Without it, the GAP state, its
// counter and the GAP_CYC parameter do not exist.
//
// Ports
//   clk_i            in   system clock
//   rst_n            in   reset, asynchronous, ACTIVE-HIGH (legacy naming)
//   req_valid_i      in   request present
//   req_ready_o      out  request accepted this cycle if valid (IDLE only)
//   req_type_i       in   0 = data update, 1 = frequency update
//   pattern_i[31:0]  in   output pattern (data) or freq pattern (freq)
//   channel_i[3:0]   in   output channel (data only)
//   mode_i           in   0 = one-shot, 1 = repeat (data only)
//   slow_period_i    in   slow period (freq only)
//   fast_period_i    in   fast period (freq only)
//   tx_start_o       out  one-clock pulse: UART TX loads tx_data_o
//   tx_data_o[7:0]   out  byte to transmit, held until its done tick
//   tx_done_tick_i   in   UART TX byte complete
//   busy_o           out  packet in progress
//   pkt_done_tick_o  out  one-clock pulse after last byte completes
//   err_tick_o       out  one-clock pulse on timeout abort
// ---------------------------------------------------------------------------
module serial_cmd_packetizer #(
  parameter logic [7:0]  CMD_DATA    = 8'h0B,
  parameter logic [7:0]  CMD_FREQ    = 8'h0A,
  parameter int unsigned TIMEOUT_CYC = 65535
`ifdef INTER_BYTE_GAP_EN
  ,
  parameter int unsigned GAP_CYC     = 16
`endif
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_type_i,
  input  logic [31:0] pattern_i,
  input  logic [3:0]  channel_i,
  input  logic        mode_i,
  input  logic [7:0]  slow_period_i,
  input  logic [7:0]  fast_period_i,
  output logic        tx_start_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_done_tick_i,
  output logic        busy_o,
  output logic        pkt_done_tick_o,
  output logic        err_tick_o
);

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC);
`ifdef INTER_BYTE_GAP_EN
  localparam logic [15:0] GAP_LAST    = 16'(GAP_CYC - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DONE
`ifdef INTER_BYTE_GAP_EN
    ,
    S_GAP
`endif
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  byte_idx;
  logic [2:0]  last_idx;
  logic [15:0] wait_cnt;
  logic [7:0]  tx_data_q;
  logic        timeout;
  logic [7:0]  pkt_buf [0:6];
`ifdef INTER_BYTE_GAP_EN
  logic [15:0] gap_cnt;
`endif

  // NOTE: this codebase's rst_n is active-HIGH despite its name, so the
  // sensitivity is posedge rst_n and the reset branch tests rst_n, not !rst_n.
  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    timeout    = 1'b0;
    case (state)
      S_IDLE:  if (req_valid_i) state_next = S_LOAD;
      S_LOAD:  state_next = S_START;
      S_START: state_next = S_WAIT;
      S_WAIT: begin
        // A done tick on the timeout clock takes priority over the abort.
        if (tx_done_tick_i) begin
          if (byte_idx == last_idx) state_next = S_DONE;
`ifdef INTER_BYTE_GAP_EN
          else                      state_next = S_GAP;
`else
          else                      state_next = S_LOAD;
`endif
        end else if (wait_cnt >= TIMEOUT_LIM) begin
          timeout    = 1'b1;
          state_next = S_IDLE;
        end
      end
`ifdef INTER_BYTE_GAP_EN
      S_GAP:   if (gap_cnt == GAP_LAST) state_next = S_LOAD;
`endif
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // wait_cnt is loaded with 1 on the start clock, so in WAIT it equals the
  // number of clocks since tx_start_o; it saturates instead of wrapping.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here sees the pre-edge values of the others.
  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      byte_idx  <= 3'd0;
      last_idx  <= 3'd5;
      wait_cnt  <= 16'd0;
      tx_data_q <= 8'h00;
`ifdef INTER_BYTE_GAP_EN
      gap_cnt   <= 16'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          byte_idx <= 3'd0;
          if (req_valid_i) last_idx <= req_type_i ? 3'd6 : 3'd5;
        end
        S_LOAD:  tx_data_q <= pkt_buf[byte_idx];
        S_START: wait_cnt  <= 16'd1;
        S_WAIT: begin
          if (tx_done_tick_i) begin
            if (byte_idx != last_idx) byte_idx <= byte_idx + 3'd1;
`ifdef INTER_BYTE_GAP_EN
            gap_cnt <= 16'd0;
`endif
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
`ifdef INTER_BYTE_GAP_EN
        S_GAP:   gap_cnt <= gap_cnt + 16'd1;
`endif
        default: ;
      endcase
    end
  end

  // NOTE: the packet buffer is pure datapath, written before it is ever read,
  // so it carries no reset and can map onto plain flops or distributed RAM.
  always_ff @(posedge clk_i) begin
    if (state == S_IDLE && req_valid_i) begin
      pkt_buf[0] <= req_type_i ? CMD_FREQ : CMD_DATA;
      pkt_buf[1] <= pattern_i[31:24];
      pkt_buf[2] <= pattern_i[23:16];
      pkt_buf[3] <= pattern_i[15:8];
      pkt_buf[4] <= pattern_i[7:0];
      pkt_buf[5] <= req_type_i ? slow_period_i : {channel_i, 1'b0, mode_i, 2'b01};
      pkt_buf[6] <= fast_period_i;
    end
  end

  assign req_ready_o     = (state == S_IDLE);
  assign busy_o          = (state != S_IDLE);
  assign tx_start_o      = (state == S_START);
  assign pkt_done_tick_o = (state == S_DONE);
  assign err_tick_o      = timeout;
  assign tx_data_o       = tx_data_q;

endmodule

// File: tb/tb_serial_cmd_packetizer.sv
// ---------------------------------------------------------------------------
// tb_serial_cmd_packetizer
//
// Self-checking bench. A UART TX model answers each start pulse with a done
// tick after a random (or forced) delay, can withhold a tick, and can emit
// stray ticks while no byte is outstanding. A cycle-indexed reference model
// derives, from the request fields and the observed done ticks, which cycle
// each start / done / error pulse must appear on and what every byte must be.
// Directed scenarios additionally compare captured byte streams and pulse
// spacings against hand-computed literals. Reset is active-high on rst_n.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_cmd_packetizer;

  localparam int TIMEOUT = 100;
`ifdef INTER_BYTE_GAP_EN
  localparam int GAP = 16;
`else
  localparam int GAP = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_type_i = 1'b0;
  logic [31:0] pattern_i = '0;
  logic [3:0]  channel_i = '0;
  logic        mode_i = 1'b0;
  logic [7:0]  slow_period_i = '0;
  logic [7:0]  fast_period_i = '0;
  logic        tx_start_o;
  logic [7:0]  tx_data_o;
  logic        tx_done_tick_i = 1'b0;
  logic        busy_o;
  logic        pkt_done_tick_o;
  logic        err_tick_o;

  serial_cmd_packetizer #(.TIMEOUT_CYC(TIMEOUT)) dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_type_i     (req_type_i),
    .pattern_i      (pattern_i),
    .channel_i      (channel_i),
    .mode_i         (mode_i),
    .slow_period_i  (slow_period_i),
    .fast_period_i  (fast_period_i),
    .tx_start_o     (tx_start_o),
    .tx_data_o      (tx_data_o),
    .tx_done_tick_i (tx_done_tick_i),
    .busy_o         (busy_o),
    .pkt_done_tick_o(pkt_done_tick_o),
    .err_tick_o     (err_tick_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [7:0] exp_q[$];
  int  exp_idx       = 0;
  bit  outstanding   = 0;
  int  start_cyc     = 0;
  logic [7:0] cur_byte = '0;
  int  exp_start_cyc = -1;
  int  exp_done_cyc  = -1;
  bit  model_idle    = 1;
  int  busy_from     = -1;
  int  idle_at       = -1;
  bit  exp_err_now;

  // DUT-observed history used by the directed literal checks
  logic [7:0] seen_q[$];
  int  n_done_ticks = 0;
  int  n_err_ticks  = 0;
  int  last_start_dut  = 0;
  int  last_err_dut    = 0;
  int  last_accept_dut = 0;
  int  first_start_after_accept = -1;

  always @(negedge clk_i) begin
    cyc++;
    if (rst_n) begin
      check("rst_ready", req_ready_o, 1);
      check("rst_busy", busy_o, 0);
      check("rst_tx_start", tx_start_o, 0);
      check("rst_tx_data", tx_data_o, 0);
      check("rst_pkt_done", pkt_done_tick_o, 0);
      check("rst_err", err_tick_o, 0);
      exp_q.delete();
      exp_idx = 0; outstanding = 0;
      exp_start_cyc = -1; exp_done_cyc = -1;
      model_idle = 1; busy_from = -1; idle_at = -1;
    end else begin
      if (idle_at == cyc)   model_idle = 1;
      if (busy_from == cyc) model_idle = 0;
      exp_err_now = 0;
      if (outstanding) begin
        check("tx_data_hold", tx_data_o, cur_byte);
        if (tx_done_tick_i) begin
          outstanding = 0;
          exp_idx++;
          if (exp_idx == exp_q.size()) begin
            exp_done_cyc = cyc + 1;
            idle_at      = cyc + 2;
          end else begin
            exp_start_cyc = cyc + 2 + GAP;
          end
        end else if (cyc - start_cyc >= TIMEOUT) begin
          exp_err_now = 1;
          outstanding = 0;
          idle_at     = cyc + 1;
        end
      end
      check("err_tick", err_tick_o, exp_err_now);
      check("tx_start", tx_start_o, cyc == exp_start_cyc);
      if (cyc == exp_start_cyc) begin
        check("tx_byte", tx_data_o, exp_q[exp_idx]);
        outstanding = 1;
        start_cyc   = cyc;
        cur_byte    = exp_q[exp_idx];
      end
      check("pkt_done", pkt_done_tick_o, cyc == exp_done_cyc);
      check("req_ready", req_ready_o, model_idle);
      check("busy", busy_o, !model_idle);
      if (req_valid_i && model_idle) begin
        exp_q.delete();
        exp_q.push_back(req_type_i ? 8'h0A : 8'h0B);
        exp_q.push_back(pattern_i[31:24]);
        exp_q.push_back(pattern_i[23:16]);
        exp_q.push_back(pattern_i[15:8]);
        exp_q.push_back(pattern_i[7:0]);
        if (req_type_i) begin
          exp_q.push_back(slow_period_i);
          exp_q.push_back(fast_period_i);
        end else begin
          exp_q.push_back({channel_i, 1'b0, mode_i, 2'b01});
        end
        exp_idx       = 0;
        exp_start_cyc = cyc + 2;
        busy_from     = cyc + 1;
        idle_at       = -1;
      end
    end
    // raw observations of the DUT
    if (!rst_n) begin
      if (req_valid_i && req_ready_o) begin
        last_accept_dut = cyc;
        first_start_after_accept = -1;
      end
      if (tx_start_o) begin
        seen_q.push_back(tx_data_o);
        last_start_dut = cyc;
        if (first_start_after_accept < 0) first_start_after_accept = cyc;
      end
      if (pkt_done_tick_o) n_done_ticks++;
      if (err_tick_o) begin
        n_err_ticks++;
        last_err_dut = cyc;
      end
    end
  end

  // ---------------- UART TX model ----------------
  bit tx_busy        = 0;
  int tx_left        = 0;
  int tx_fixed_delay = 0;
  int tx_hold_byte   = -1;
  int tx_byte_no     = 0;
  bit spur_en        = 0;

  always @(posedge clk_i) begin
    #1;
    if (rst_n) begin
      tx_busy = 0;
      tx_done_tick_i = 1'b0;
    end else begin
      tx_done_tick_i = 1'b0;
      if (tx_busy) begin
        tx_left--;
        if (tx_left == 0) begin
          tx_done_tick_i = 1'b1;
          tx_busy = 0;
        end
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
        tx_done_tick_i = 1'b1;
      end
      if (tx_start_o) begin
        if (tx_byte_no != tx_hold_byte) begin
          tx_busy = 1;
          tx_left = (tx_fixed_delay > 0) ? tx_fixed_delay : int'($urandom_range(1, 6));
        end
        tx_byte_no++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic set_fields(input bit typ, input logic [31:0] pat, input logic [3:0] ch,
                            input bit md, input logic [7:0] slow, input logic [7:0] fast);
    req_type_i = typ; pattern_i = pat; channel_i = ch;
    mode_i = md; slow_period_i = slow; fast_period_i = fast;
  endtask

  task automatic scramble_fields();
    set_fields(1'($urandom), $urandom, 4'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic send(input bit typ, input logic [31:0] pat, input logic [3:0] ch,
                      input bit md, input logic [7:0] slow, input logic [7:0] fast);
    bit got = 0;
    set_fields(typ, pat, ch, md, slow, fast);
    req_valid_i = 1'b1;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk_i);
      if (req_ready_o) got = 1;
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    scramble_fields();
    check("accept_within_budget", 32'(got), 1);
  endtask

  task automatic wait_idle(input int budget);
    bit idle = 0;
    for (int i = 0; i < budget && !idle; i++) begin
      @(negedge clk_i);
      if (req_ready_o) idle = 1;
    end
    @(posedge clk_i); #1;
    check("idle_within_budget", 32'(idle), 1);
  endtask

  task automatic check_bytes(input string name, input logic [7:0] exp[$]);
    check({name, "_len"}, seen_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < seen_q.size(); i++)
      check($sformatf("%s[%0d]", name, i), seen_q[i], exp[i]);
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int dones0, errs0;
    bit hit;
    repeat (3) @(posedge clk_i);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    // 1: data, ch=3 mode=1 -> control byte {0011,0,1,01} = 8'h35
    seen_q.delete(); dones0 = n_done_ticks;
    send(1'b0, 32'h5555_5555, 4'd3, 1'b1, 8'h00, 8'h00);
    wait_idle(500);
    check_bytes("t1_bytes", '{8'h0B, 8'h55, 8'h55, 8'h55, 8'h55, 8'h35});
    check("t1_done_count", n_done_ticks - dones0, 1);
    check("t1_accept_to_start", first_start_after_accept - last_accept_dut, 2);

    // 2: frequency update
    seen_q.delete(); dones0 = n_done_ticks;
    send(1'b1, 32'h1122_3344, 4'd0, 1'b0, 8'h14, 8'h05);
    wait_idle(500);
    check_bytes("t2_bytes", '{8'h0A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h14, 8'h05});
    check("t2_done_count", n_done_ticks - dones0, 1);

    // 3: valid held with changing fields during a packet, then a second request
    seen_q.delete(); dones0 = n_done_ticks;
    send(1'b0, 32'hA1B2_C3D4, 4'd5, 1'b0, 8'h00, 8'h00);
    req_valid_i = 1'b1;
    repeat (8) begin
      scramble_fields();
      @(posedge clk_i); #1;
    end
    send(1'b1, 32'hDEAD_BEEF, 4'd0, 1'b0, 8'h33, 8'h44);
    wait_idle(1000);
    check_bytes("t3_bytes", '{8'h0B, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h51,
                              8'h0A, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h33, 8'h44});
    check("t3_done_count", n_done_ticks - dones0, 2);

    // 4: done tick withheld on byte index 2 -> abort 100 clocks after its start
    seen_q.delete(); dones0 = n_done_ticks; errs0 = n_err_ticks;
    tx_byte_no = 0; tx_hold_byte = 2;
    send(1'b0, 32'h0102_0304, 4'd1, 1'b0, 8'h00, 8'h00);
    wait_idle(1000);
    tx_hold_byte = -1;
    check("t4_err_count", n_err_ticks - errs0, 1);
    check("t4_err_delay", last_err_dut - last_start_dut, 100);
    check("t4_no_done", n_done_ticks - dones0, 0);
    check("t4_bytes_sent", seen_q.size(), 3);

    // 4b: done tick exactly on the timeout clock wins
    dones0 = n_done_ticks; errs0 = n_err_ticks;
    tx_fixed_delay = TIMEOUT;
    send(1'b0, 32'hCAFE_F00D, 4'd2, 1'b1, 8'h00, 8'h00);
    wait_idle(2000);
    check("t4b_no_err", n_err_ticks - errs0, 0);
    check("t4b_done", n_done_ticks - dones0, 1);

    // 4c: one clock too late -> abort on the first byte, late tick ignored
    seen_q.delete(); errs0 = n_err_ticks;
    tx_fixed_delay = TIMEOUT + 1;
    send(1'b1, 32'h7777_8888, 4'd0, 1'b0, 8'h01, 8'h02);
    wait_idle(500);
    repeat (4) @(posedge clk_i);
    #1;
    check("t4c_err", n_err_ticks - errs0, 1);
    check("t4c_bytes_sent", seen_q.size(), 1);

    // 5: reset pulse during the fourth byte, then a clean packet
    tx_fixed_delay = 4;
    seen_q.delete();
    send(1'b1, 32'h9999_9999, 4'd0, 1'b0, 8'h10, 8'h20);
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(posedge clk_i); #1;
      if (seen_q.size() == 4) hit = 1;
    end
    check("t5_reached_byte3", 32'(hit), 1);
    @(posedge clk_i); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1'b0;
    tx_fixed_delay = 0;
    seen_q.delete(); dones0 = n_done_ticks;
    send(1'b0, 32'h1234_5678, 4'd0, 1'b0, 8'h00, 8'h00);
    wait_idle(500);
    check_bytes("t5_bytes", '{8'h0B, 8'h12, 8'h34, 8'h56, 8'h78, 8'h01});
    check("t5_done_count", n_done_ticks - dones0, 1);

    // random phase: stray ticks enabled, model checks every cycle
    spur_en = 1;
    dones0 = n_done_ticks;
    for (int p = 0; p < 60; p++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk_i);
      #1;
      send(1'($urandom), $urandom, 4'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 0) wait_idle(1000);
    end
    wait_idle(1000);
    spur_en = 0;
    check("rand_done_count", n_done_ticks - dones0, 60);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
